mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA memory bus arbiter with fixed-latency transactions
// Round-robin tie-break by default; define ARB_CPU_PRIORITY_EN for fixed CPU priority.
module mem_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_address,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] bus_address,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] bus_address_q, bus_address_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          bus_we_q, bus_we_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          pick_dma;

    always_comb begin
`ifdef ARB_CPU_PRIORITY_EN
        pick_dma = dma_req && !cpu_req;
`else
        // grant_q holds the last owner; on a tie the other requester wins
        pick_dma = dma_req && (!cpu_req || !grant_q);
`endif
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        we_d          = we_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        bus_we_d      = 1'b0;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_d       = pick_dma;
                    bus_address_d = pick_dma ? dma_address : cpu_address;
                    bus_wdata_d   = pick_dma ? dma_wdata : cpu_wdata;
                    we_d          = pick_dma ? dma_we : cpu_we;
                    // strobe is registered so it is high exactly during ACCESS
                    bus_we_d      = pick_dma ? dma_we : cpu_we;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d   = 3'(RD_LATENCY);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    if (!we_q) begin
                        if (grant_q) dma_rdata_d = bus_rdata;
                        else         cpu_rdata_d = bus_rdata;
                    end
                    cpu_ack_d = !grant_q;
                    dma_ack_d = grant_q;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            grant_q       <= 1'b1;
            we_q          <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_we_q      <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            we_q          <= we_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_we_q      <= bus_we_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign bus_address = bus_address_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_we      = bus_we_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
